// File: rtl/mult32x32_req_adapter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult32x32_req_adapter : valid/ready front-end for the 32x32 multiplier core.
// Optional: define MULT_ZERO_BYPASS_EN to answer zero-operand requests without
// starting the core.                                  Revision: 1.0
// ---------------------------------------------------------------------------
module mult32x32_req_adapter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             mult_start,
  output logic [31:0]      mult_a,
  output logic [31:0]      mult_b,
  input  logic             mult_busy,
  input  logic [63:0]      mult_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_product,
  output logic [CNT_W-1:0] out_cycles
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] busy_cnt;
  logic             accept;
  logic             zero_req;

  assign accept = in_valid && (state == IDLE);

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_req = (in_a == 32'd0) || (in_b == 32'd0);
`else
  assign zero_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = zero_req ? RESP : LAUNCH;
      LAUNCH:  state_next = RUN;
      RUN:     if (!mult_busy) state_next = RESP;
      RESP:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    mult_start = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE:    in_ready   = 1'b1;
      LAUNCH:  mult_start = 1'b1;
      RESP:    out_valid  = 1'b1;
      default: ;
    endcase
  end

  // Operands are only written on acceptance so the core sees them stable
  // for the whole operation; results persist until the next capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mult_a      <= 32'd0;
      mult_b      <= 32'd0;
      busy_cnt    <= '0;
      out_product <= 64'd0;
      out_cycles  <= '0;
    end else begin
      if (accept) begin
        mult_a   <= in_a;
        mult_b   <= in_b;
        busy_cnt <= '0;
        if (zero_req) begin
          out_product <= 64'd0;
          out_cycles  <= '0;
        end
      end else if (state == RUN) begin
        if (mult_busy) begin
          if (busy_cnt != CNT_MAX) busy_cnt <= busy_cnt + 1'b1;
        end else begin
          out_product <= mult_product;
          out_cycles  <= busy_cnt;
        end
      end
    end
  end

endmodule
`default_nettype wire
